// File: rtl/slider_move_gen_if.sv
// Move stream from the slider generator to the move list.
// Valid/ready handshake carrying one (from,to,capture) move.
interface slider_move_gen_if;
  logic       move_valid;
  logic       move_ready;
  logic [5:0] move_from;
  logic [5:0] move_to;
  logic       move_capture;

  modport master (
    output move_valid,
    output move_from,
    output move_to,
    output move_capture,
    input  move_ready
  );

  modport slave (
    input  move_valid,
    input  move_from,
    input  move_to,
    input  move_capture,
    output move_ready
  );
endinterface

// File: rtl/slider_move_gen.sv
// Sequential rook/queen line move emitter.
// Walks sliders lowest-first, one move per handshake.
module slider_move_gen #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [63:0]        sliders,
  input  logic [63:0]        own,
  input  logic [63:0]        occupied,
  output logic [63:0]        la_occupied,
  output logic [2:0]         la_file,
  output logic [2:0]         la_rank,
  input  logic [63:0]        la_attack,
  slider_move_gen_if.master  mv,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] move_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ATTACK,
    S_EMIT,
    S_DONE
  } state_t;

  state_t      state;
  logic [63:0] pieces_q;
  logic [63:0] own_q;
  logic [63:0] occ_q;
  logic [63:0] tgt_q;
  logic [5:0]  from_q;
  logic [5:0]  to_sq;
  logic        accept;

  function automatic logic [5:0] lsb_idx(input logic [63:0] v);
    logic [5:0] r;
    r = '0;
    for (int i = 63; i >= 0; i--)
      if (v[i]) r = 6'(i);
    return r;
  endfunction

  // Outputs decoded straight from registered state.
  always_comb begin
    to_sq           = lsb_idx(tgt_q);
    mv.move_valid   = (state == S_EMIT) && (tgt_q != '0);
    mv.move_from    = from_q;
    mv.move_to      = to_sq;
    mv.move_capture = occ_q[to_sq];
    accept          = mv.move_valid && mv.move_ready;
    la_occupied     = occ_q;
    la_file         = from_q[2:0];
    la_rank         = from_q[5:3];
    busy            = (state != S_IDLE);
    done            = (state == S_DONE);
  end

  // Control FSM: select piece, query attacks, stream targets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pieces_q   <= '0;
      own_q      <= '0;
      occ_q      <= '0;
      tgt_q      <= '0;
      from_q     <= '0;
      move_count <= '0;
    end else if (abort) begin
      state <= S_IDLE;
      tgt_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            pieces_q   <= sliders;
            own_q      <= own;
            occ_q      <= occupied;
            move_count <= '0;
            state      <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (pieces_q == '0) begin
            state <= S_DONE;
          end else begin
            from_q   <= lsb_idx(pieces_q);
            pieces_q <= pieces_q & (pieces_q - 64'd1);
            state    <= S_ATTACK;
          end
        end
        S_ATTACK: begin
          tgt_q <= la_attack & ~own_q;
          state <= S_EMIT;
        end
        S_EMIT: begin
          if (tgt_q == '0) begin
            state <= S_SELECT;
          end else if (accept) begin
            tgt_q <= tgt_q & (tgt_q - 64'd1);
            if (move_count != '1)
              move_count <= move_count + 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slider_move_gen.sv
// Directed bench for slider_move_gen.
// Includes a behavioural line-attack stage and move collector.
module tb_slider_move_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [63:0] sliders;
  logic [63:0] own;
  logic [63:0] occupied;
  logic [63:0] la_occupied;
  logic [2:0]  la_file;
  logic [2:0]  la_rank;
  logic [63:0] la_attack;
  logic        busy;
  logic        done;
  logic [7:0]  move_count;

  slider_move_gen_if bus ();

  slider_move_gen #(.COUNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .sliders     (sliders),
    .own         (own),
    .occupied    (occupied),
    .la_occupied (la_occupied),
    .la_file     (la_file),
    .la_rank     (la_rank),
    .la_attack   (la_attack),
    .mv          (bus),
    .busy        (busy),
    .done        (done),
    .move_count  (move_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rook_att(
    input logic [63:0] occ, input int f, input int r);
    logic [63:0] a;
    int x, y, df, dr;
    a = '0;
    for (int d = 0; d < 4; d++) begin
      df = (d == 0) ? 1 : (d == 1) ? -1 : 0;
      dr = (d == 2) ? 1 : (d == 3) ? -1 : 0;
      x = f + df;
      y = r + dr;
      while (x >= 0 && x < 8 && y >= 0 && y < 8) begin
        a[y*8+x] = 1'b1;
        if (occ[y*8+x]) break;
        x += df;
        y += dr;
      end
    end
    return a;
  endfunction

  always_comb
    la_attack = rook_att(la_occupied, int'(la_file), int'(la_rank));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [12:0] got_q[$];
  logic [12:0] exp_q[$];
  int n_acc, acc_cyc, done_cyc, first_valid;
  bit saw_done;

  task automatic add(input int f, input int t, input bit c);
    exp_q.push_back({6'(f), 6'(t), c});
  endtask

  task automatic cmp_list(input string tag);
    check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check(tag, 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic run(input logic [63:0] s, input logic [63:0] o,
                     input logic [63:0] oc, input int stall_idx,
                     input int abort_after, input int max_cyc);
    bit pending;
    bit aborted;
    int stall_left;
    logic [12:0] held;
    got_q.delete();
    n_acc = 0;
    acc_cyc = -1;
    done_cyc = -1;
    first_valid = -1;
    saw_done = 0;
    pending = 0;
    aborted = 0;
    stall_left = 4;
    held = '0;
    @(negedge clk);
    sliders = s;
    own = o;
    occupied = oc;
    bus.move_ready = 1'b1;
    start = 1'b1;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.move_valid && first_valid < 0) first_valid = cyc;
      if (pending) begin
        check("hold_valid", 64'(bus.move_valid), 64'd1);
        check("hold_move",
              64'({bus.move_from, bus.move_to, bus.move_capture}),
              64'(held));
      end
      if (done) begin
        done_cyc = cyc;
        saw_done = 1;
        break;
      end
      if (abort_after >= 0 && n_acc == abort_after && bus.move_valid) begin
        abort = 1'b1;
        bus.move_ready = 1'b0;
        aborted = 1;
        break;
      end
      if (bus.move_valid) begin
        if (n_acc == stall_idx && stall_left > 0) begin
          bus.move_ready = 1'b0;
          stall_left--;
          check("cnt_stall", 64'(move_count), 64'(n_acc));
          pending = 1;
          held = {bus.move_from, bus.move_to, bus.move_capture};
          if (stall_left == 3) begin
            start = 1'b1;
            sliders = ~s;
          end
        end else begin
          bus.move_ready = 1'b1;
          pending = 0;
          got_q.push_back({bus.move_from, bus.move_to, bus.move_capture});
          n_acc++;
          acc_cyc = cyc;
        end
      end else begin
        pending = 0;
        bus.move_ready = 1'b1;
      end
    end
    start = 1'b0;
    if (!aborted) check("done_seen", 64'(saw_done), 64'd1);
  endtask

  task automatic exp_corner;
    exp_q.delete();
    for (int t = 1; t < 8; t++) add(0, t, 1'b0);
    for (int t = 8; t < 64; t += 8) add(0, t, 1'b0);
  endtask

  initial begin
    bit done_hit;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    sliders = '0;
    own = '0;
    occupied = '0;
    bus.move_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(bus.move_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(move_count), 64'd0);
    rst_n = 1'b1;

    // reset while a move is pending
    @(negedge clk);
    sliders = 64'h1;
    own = 64'h1;
    occupied = 64'h1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !bus.move_valid; i++) @(negedge clk);
    check("pend_valid", 64'(bus.move_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.move_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_la", la_occupied, 64'd0);
    check("arst_mv",
          64'({bus.move_from, bus.move_to, bus.move_capture}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // lone rook in the corner, empty board
    exp_corner();
    run(64'h1, 64'h1, 64'h1, -1, -1, 200);
    cmp_list("corner");
    check("corner_cnt", 64'(move_count), 64'd14);
    check("corner_lat", 64'(first_valid), 64'd3);
    check("corner_done", 64'(done_cyc - acc_cyc), 64'd3);

    // blockers with captures
    exp_q.delete();
    add(0, 1, 0);
    add(0, 2, 0);
    add(0, 3, 1);
    add(0, 8, 0);
    add(0, 16, 1);
    run(64'h1, 64'h1, 64'h0000_0000_0001_0009, -1, -1, 200);
    cmp_list("block");
    check("block_cnt", 64'(move_count), 64'd5);

    // backpressure on second move, start ignored mid-run
    exp_corner();
    run(64'h1, 64'h1, 64'h1, 1, -1, 200);
    cmp_list("stall");
    check("stall_cnt", 64'(move_count), 64'd14);

    // two rooks behind a full own rank
    exp_q.delete();
    for (int t = 8; t < 64; t += 8) add(0, t, 0);
    for (int t = 15; t < 64; t += 8) add(7, t, 0);
    run(64'h81, 64'hFF, 64'hFF, -1, -1, 200);
    cmp_list("rank1");
    check("rank1_cnt", 64'(move_count), 64'd14);

    // abort during emission of a three rook run
    run(64'h8000_0000_0800_0001, 64'h8000_0000_0800_0001,
        64'h8000_0000_0800_0001, -1, 5, 200);
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", 64'(bus.move_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_cnt", 64'(move_count), 64'd5);
    done_hit = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) done_hit = 1;
    end
    check("abort_nodone", 64'(done_hit), 64'd0);
    exp_corner();
    run(64'h1, 64'h1, 64'h1, -1, -1, 200);
    cmp_list("restart");
    check("restart_cnt", 64'(move_count), 64'd14);

    // no sliders at all
    run(64'h0, 64'h0, 64'h0, -1, -1, 50);
    check("empty_moves", 64'(got_q.size()), 64'd0);
    check("empty_done", 64'(done_cyc), 64'd2);
    check("empty_cnt", 64'(move_count), 64'd0);

    // piece with no targets
    run(64'h1, '1, '1, -1, -1, 50);
    check("blocked_moves", 64'(got_q.size()), 64'd0);
    check("blocked_done", 64'(done_cyc), 64'd5);

    // start together with abort in idle
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", 64'(busy), 64'd0);

    // count saturation with 64 rooks
    run('1, 64'h0, 64'h0, -1, -1, 3000);
    check("sat_moves", 64'(n_acc), 64'd896);
    check("sat_cnt", 64'(move_count), 64'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
